mc_ctrl: RTL and testbench

Multi-cycle MIPS main controller; successor to the single-cycle opcode decoder. It sequences each instruction through fetch/decode/execute/memory/writeback states instead of decoding in one combinational step. It waits on memory-ready handshakes, bounds those waits with a timeout counter, and flags illegal opcodes. It sits between the instruction register (opcode source) and the shared datapath (PC, IR, ALU, register file, unified memory port).

---
 rtl/mc_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller.
// Steps each instruction through fetch/decode/execute/memory/writeback,
// waits on mem_ready with a bounded timeout, and flags illegal opcodes.
module mc_ctrl #(
    parameter int TIMEOUT         = 16,
    parameter int TRAP_ON_ILLEGAL = 1,
    parameter int CNT_W           = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       Ext_op,
    output logic       illegal,
    output logic       retire,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_LWWB   = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXE   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JMP    = 4'd9,
        S_IEXE   = 4'd10,
        S_IWB    = 4'd11,
        S_FAULT  = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // Timeout fires on the wait cycle whose increment would make the counter reach TIMEOUT
    localparam bit              TO_EN     = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit              TRAP      = (TRAP_ON_ILLEGAL != 0);

    state_t           cur_state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             ill_pulse;
    logic             in_wait;
    logic             timeout_hit;
    logic             fault_take;

    assign state       = cur_state;
    assign in_wait     = (cur_state == S_FETCH) || (cur_state == S_MEMRD) || (cur_state == S_MEMWR);
    assign timeout_hit = TO_EN && in_wait && !mem_ready && (wait_cnt == LAST_WAIT);

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    // Wait counter counts unanswered memory cycles; the pulse flag marks a non-trapping fault
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= '0;
            ill_pulse <= 1'b0;
        end else begin
            if (in_wait && !mem_ready && !fault_take) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            ill_pulse <= fault_take && !TRAP;
        end
    end

    // Next-state selection, including opcode dispatch and the fault path
    always_comb begin
        next_state = cur_state;
        fault_take = 1'b0;
        case (cur_state)
            S_FETCH: begin
                if (mem_ready)        next_state = S_DECODE;
                else if (timeout_hit) fault_take = 1'b1;
            end
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:                          next_state = S_REXE;
                    OP_LW, OP_SW:                      next_state = S_MEMADR;
                    OP_BEQ:                            next_state = S_BEQ;
                    OP_J:                              next_state = S_JMP;
                    OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: next_state = S_IEXE;
                    default:                           fault_take = 1'b1;
                endcase
            end
            S_MEMADR: next_state = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)        next_state = S_LWWB;
                else if (timeout_hit) fault_take = 1'b1;
            end
            S_LWWB: next_state = S_FETCH;
            S_MEMWR: begin
                if (mem_ready)        next_state = S_FETCH;
                else if (timeout_hit) fault_take = 1'b1;
            end
            S_REXE:  next_state = S_RWB;
            S_RWB:   next_state = S_FETCH;
            S_BEQ:   next_state = S_FETCH;
            S_JMP:   next_state = S_FETCH;
            S_IEXE:  next_state = S_IWB;
            S_IWB:   next_state = S_FETCH;
            S_FAULT: next_state = S_FAULT;
            default: next_state = S_FETCH;
        endcase
        if (fault_take) begin
            next_state = TRAP ? S_FAULT : S_FETCH;
        end
    end

    // Datapath controls decoded from state; only fetch loads and retire look at mem_ready
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;
        Ext_op      = 1'b0;
        retire      = 1'b0;
        illegal     = ill_pulse;
        case (cur_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                Ext_op  = 1'b1;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                Ext_op  = 1'b1;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_LWWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                retire   = mem_ready;
            end
            S_REXE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b010;
            end
            S_RWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                retire      = 1'b1;
            end
            S_JMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                retire   = 1'b1;
            end
            S_IEXE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (Opcode)
                    OP_ORI:  ALUOp = 3'b100;
                    OP_LUI:  ALUOp = 3'b011;
                    default: begin
                        ALUOp  = 3'b000;
                        Ext_op = 1'b1;
                    end
                endcase
            end
            S_IWB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_FAULT: begin
                ALUOp   = 3'b111;
                illegal = 1'b1;
            end
            default: begin
                ALUOp = 3'b000;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl (TIMEOUT=4, trapping faults).
// Stimulus pushes the hand-derived state and control word for each cycle;
// a negedge monitor pops and compares them against the DUT.
module tb_mc_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] Opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Ext_op, illegal, retire;
    logic [1:0] PCSource, ALUSrcB;
    logic [2:0] ALUOp;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0]  st;
        logic [19:0] ctl;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    logic [19:0] f_wait, f_rdy, dec, madr, mrd, lwwb, mwr_w, mwr_r;
    logic [19:0] rexe, rwb, beq_c, jmp_c, iexe_add, iexe_ori, iexe_lui, iwb, flt;

    mc_ctrl #(.TIMEOUT(4), .TRAP_ON_ILLEGAL(1), .CNT_W(5)) u_dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .Ext_op(Ext_op),
        .illegal(illegal), .retire(retire), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs one control word in a fixed field order shared with checkOutput
    function automatic logic [19:0] mk(input logic pcw, input logic pcwc, input logic [1:0] pcs,
                                       input logic iord, input logic mr, input logic mw,
                                       input logic irw, input logic m2r, input logic rdst,
                                       input logic rw, input logic asa, input logic [1:0] asb,
                                       input logic [2:0] aop, input logic ext, input logic ill,
                                       input logic ret);
        return {pcw, pcwc, pcs, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, ext, ill, ret};
    endfunction

    // Compares one scoreboard entry against what the DUT shows right now
    task automatic checkOutput(input exp_t e);
        logic [19:0] act;
        act = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, Ext_op, illegal, retire};
        checks++;
        if (state !== e.st || act !== e.ctl) begin
            errors++;
            $display("[TB] FAIL cycle%0d: got state=%0d ctl=%b, need state=%0d ctl=%b",
                     step, state, act, e.st, e.ctl);
        end
        step++;
    endtask

    // Drives one cycle of inputs and queues the response expected during that cycle
    task automatic applyStimulus(input logic [5:0] op, input logic rdy,
                                 input logic [3:0] st, input logic [19:0] ctl);
        exp_t e;
        Opcode    = op;
        mem_ready = rdy;
        e.st      = st;
        e.ctl     = ctl;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        applyStimulus(6'd0, 1'b0, 4'd0, f_wait);
        rst = 1'b1;
    endtask

    // Monitor: every cycle with a pending expectation is compared mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            checkOutput(sb.pop_front());
        end
    end

    initial begin
        //            pcw pcwc pcs  iord mr mw irw m2r rdst rw asa asb   aop     ext ill ret
        f_wait   = mk(0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd1, 3'd0, 0, 0, 0);
        f_rdy    = mk(1, 0, 2'd0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd1, 3'd0, 0, 0, 0);
        dec      = mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 3'd0, 1, 0, 0);
        madr     = mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 3'd0, 1, 0, 0);
        mrd      = mk(0, 0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 0);
        lwwb     = mk(0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 3'd0, 0, 0, 1);
        mwr_w    = mk(0, 0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 0);
        mwr_r    = mk(0, 0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 1);
        rexe     = mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 3'd2, 0, 0, 0);
        rwb      = mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 3'd0, 0, 0, 1);
        beq_c    = mk(0, 1, 2'd1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 3'd1, 0, 0, 1);
        jmp_c    = mk(1, 0, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 1);
        iexe_add = mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 3'd0, 1, 0, 0);
        iexe_ori = mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 3'd4, 0, 0, 0);
        iexe_lui = mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 3'd3, 0, 0, 0);
        iwb      = mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 3'd0, 0, 0, 1);
        flt      = mk(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 3'd7, 0, 1, 0);

        rst       = 1'b0;
        Opcode    = 6'd0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        doReset();

        // R-type: 0,1,6,7
        applyStimulus(6'b000000, 1'b1, 4'd0, f_rdy);
        applyStimulus(6'b000000, 1'b0, 4'd1, dec);
        applyStimulus(6'b000000, 1'b0, 4'd6, rexe);
        applyStimulus(6'b000000, 1'b0, 4'd7, rwb);

        // LW with three stalled memory cycles: 0,1,2,3,3,3,3,4
        applyStimulus(6'b100011, 1'b1, 4'd0, f_rdy);
        applyStimulus(6'b100011, 1'b0, 4'd1, dec);
        applyStimulus(6'b100011, 1'b0, 4'd2, madr);
        for (int i = 0; i < 3; i++) applyStimulus(6'b100011, 1'b0, 4'd3, mrd);
        applyStimulus(6'b100011, 1'b1, 4'd3, mrd);
        applyStimulus(6'b100011, 1'b0, 4'd4, lwwb);

        // SW (4 cycles), then SW with one stall, then BEQ (3 cycles)
        applyStimulus(6'b101011, 1'b1, 4'd0, f_rdy);
        applyStimulus(6'b101011, 1'b1, 4'd1, dec);
        applyStimulus(6'b101011, 1'b1, 4'd2, madr);
        applyStimulus(6'b101011, 1'b1, 4'd5, mwr_r);
        applyStimulus(6'b101011, 1'b1, 4'd0, f_rdy);
        applyStimulus(6'b101011, 1'b0, 4'd1, dec);
        applyStimulus(6'b101011, 1'b0, 4'd2, madr);
        applyStimulus(6'b101011, 1'b0, 4'd5, mwr_w);
        applyStimulus(6'b101011, 1'b1, 4'd5, mwr_r);
        applyStimulus(6'b000100, 1'b1, 4'd0, f_rdy);
        applyStimulus(6'b000100, 1'b1, 4'd1, dec);
        applyStimulus(6'b000100, 1'b1, 4'd8, beq_c);

        // Jump
        applyStimulus(6'b000010, 1'b1, 4'd0, f_rdy);
        applyStimulus(6'b000010, 1'b0, 4'd1, dec);
        applyStimulus(6'b000010, 1'b0, 4'd9, jmp_c);

        // Immediate forms: ORI, LUI, ADDI, ADDIU
        applyStimulus(6'b001101, 1'b1, 4'd0, f_rdy);
        applyStimulus(6'b001101, 1'b0, 4'd1, dec);
        applyStimulus(6'b001101, 1'b0, 4'd10, iexe_ori);
        applyStimulus(6'b001101, 1'b0, 4'd11, iwb);
        applyStimulus(6'b001111, 1'b1, 4'd0, f_rdy);
        applyStimulus(6'b001111, 1'b0, 4'd1, dec);
        applyStimulus(6'b001111, 1'b0, 4'd10, iexe_lui);
        applyStimulus(6'b001111, 1'b0, 4'd11, iwb);
        applyStimulus(6'b001000, 1'b1, 4'd0, f_rdy);
        applyStimulus(6'b001000, 1'b0, 4'd1, dec);
        applyStimulus(6'b001000, 1'b0, 4'd10, iexe_add);
        applyStimulus(6'b001000, 1'b0, 4'd11, iwb);
        applyStimulus(6'b001001, 1'b1, 4'd0, f_rdy);
        applyStimulus(6'b001001, 1'b0, 4'd1, dec);
        applyStimulus(6'b001001, 1'b0, 4'd10, iexe_add);
        applyStimulus(6'b001001, 1'b0, 4'd11, iwb);

        // Fetch completes on the 4th wait cycle: no timeout, decode follows
        for (int i = 0; i < 3; i++) applyStimulus(6'b000000, 1'b0, 4'd0, f_wait);
        applyStimulus(6'b000000, 1'b1, 4'd0, f_rdy);
        applyStimulus(6'b000000, 1'b0, 4'd1, dec);
        applyStimulus(6'b000000, 1'b0, 4'd6, rexe);
        applyStimulus(6'b000000, 1'b0, 4'd7, rwb);

        // Illegal opcode traps and holds for 20 cycles, reset recovers
        applyStimulus(6'b111111, 1'b1, 4'd0, f_rdy);
        applyStimulus(6'b111111, 1'b0, 4'd1, dec);
        for (int i = 0; i < 20; i++) applyStimulus(6'b111111, 1'(i % 2), 4'd15, flt);
        doReset();

        // Fetch stuck for 4 wait cycles times out into FAULT
        for (int i = 0; i < 4; i++) applyStimulus(6'b000000, 1'b0, 4'd0, f_wait);
        for (int i = 0; i < 3; i++) applyStimulus(6'b000000, 1'b0, 4'd15, flt);
        doReset();
        applyStimulus(6'b000000, 1'b1, 4'd0, f_rdy);
        applyStimulus(6'b000000, 1'b0, 4'd1, dec);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending entries, need 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
